// File: rtl/pc_score_pkg.sv
// Shared types for the PC score counter: FSM states, BCD digit type and
// the two-digit score with its increment helper.
package pc_score_pkg;

  localparam int unsigned BCD_W = 4;

  typedef logic [BCD_W-1:0] bcd_t;

  localparam bcd_t BCD_MAX = bcd_t'(9);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  typedef struct packed {
    bcd_t tens;
    bcd_t ones;
  } score_t;

  // Two-digit BCD increment; 99 wraps to 00.
  function automatic score_t score_inc(input score_t s);
    score_t r;
    r = s;
    if (s.ones == BCD_MAX) begin
      r.ones = '0;
      r.tens = (s.tens == BCD_MAX) ? '0 : s.tens + bcd_t'(1);
    end else begin
      r.ones = s.ones + bcd_t'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/pc_score_counter_if.sv
// Control/score bus between the PC score counter and its environment.
interface pc_score_counter_if
  import pc_score_pkg::*;
#(
  parameter int unsigned PERIOD_W = 26
) ();

  logic                start;
  logic                pause;
  logic [PERIOD_W-1:0] period;
  logic                step;
  logic                ended;
  bcd_t                q0;
  bcd_t                q1;

  modport master(output start, pause, period, input step, ended, q0, q1);
  modport slave(input start, pause, period, output step, ended, q0, q1);

endinterface

// File: rtl/pc_rate_divider.sv
// Down-counting step divider: ticks when the count sits at zero and is
// neither being loaded nor held, reloading from reload_val on that edge.
module pc_rate_divider #(
  parameter int unsigned WIDTH = 26
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             hold,
  input  logic [WIDTH-1:0] reload_val,
  output logic             tick
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= reload_val;
    end else if (!hold) begin
      count_q <= (count_q == '0) ? reload_val : count_q - WIDTH'(1);
    end
  end

  assign tick = !load && !hold && (count_q == '0);

endmodule

// File: rtl/pc_score_counter.sv
// PC race score counter: BCD score advancing one box per divider interval.
// Optional PC_SCORE_SPEEDUP_EN halves the interval on every ones-digit carry.
module pc_score_counter
  import pc_score_pkg::*;
#(
  parameter int unsigned PERIOD_W    = 26,
  parameter bcd_t        TARGET_TENS = 4'd3,
  parameter bcd_t        TARGET_ONES = 4'd2
) (
  input logic               clk,
  input logic               reset,
  pc_score_counter_if.slave bus
);

  localparam score_t TARGET = {TARGET_TENS, TARGET_ONES};

  state_t              state_q, state_d;
  score_t              score_q, score_d, score_next;
  logic                ended_q, ended_d;
  logic                step_q, step_d;
  logic                load, hold, tick;
  logic [PERIOD_W-1:0] period_eff;
  logic [PERIOD_W-1:0] reload_val;

  // period=0 runs as period=1
  assign period_eff = (bus.period == '0) ? PERIOD_W'(1) : bus.period;
  assign hold       = (state_q != RUN) || bus.pause;
  assign score_next = score_inc(score_q);

  always_comb begin
    state_d = state_q;
    score_d = score_q;
    ended_d = ended_q;
    step_d  = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = RUN;
          score_d = '0;
          ended_d = 1'b0;
          load    = 1'b1;
        end
      end
      RUN: begin
        if (tick) begin
          step_d  = 1'b1;
          score_d = score_next;
          if (score_next == TARGET) begin
            state_d = DONE;
            ended_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      score_q <= '0;
      ended_q <= 1'b0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      ended_q <= ended_d;
      step_q  <= step_d;
    end
  end

`ifdef PC_SCORE_SPEEDUP_EN
  logic [PERIOD_W-1:0] eff_q, half_c;
  logic                carry;

  assign half_c = ((eff_q >> 1) == '0) ? PERIOD_W'(1) : (eff_q >> 1);
  assign carry  = tick && (score_q.ones == BCD_MAX);

  // Effective interval persists across the run; restart reloads from period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      eff_q <= PERIOD_W'(1);
    end else if (load) begin
      eff_q <= period_eff;
    end else if (carry) begin
      eff_q <= half_c;
    end
  end

  // The reload on the carry edge already uses the halved interval.
  assign reload_val = load  ? period_eff - PERIOD_W'(1)
                    : carry ? half_c - PERIOD_W'(1)
                    :         eff_q - PERIOD_W'(1);
`else
  assign reload_val = period_eff - PERIOD_W'(1);
`endif

  pc_rate_divider #(
    .WIDTH(PERIOD_W)
  ) u_div (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .hold      (hold),
    .reload_val(reload_val),
    .tick      (tick)
  );

  assign bus.step  = step_q;
  assign bus.ended = ended_q;
  assign bus.q0    = score_q.ones;
  assign bus.q1    = score_q.tens;

endmodule
